button_event_scheduler: RTL and testbench

//   Controller for the push-button input path. Synchronises and debounces NUM_BTN active-low

---
 rtl/button_event_scheduler.sv | 165 ++++++++++++++++
 tb/tb_button_event_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/button_event_scheduler.sv
// Push-button front end: synchronise, debounce, queue presses round-robin into an event FIFO,
// and expose the queue to the Nios II over a small Avalon-MM slave with a level interrupt.
module button_event_scheduler #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] in_port,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq
);

  localparam int IDW   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int CNTW  = $clog2(DEBOUNCE_CYCLES);
  localparam int PTRW  = $clog2(FIFO_DEPTH);
  localparam int CNTFW = PTRW + 1;

  localparam logic [CNTW-1:0]  DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTFW-1:0] FIFO_FULL = CNTFW'(FIFO_DEPTH);
  localparam logic [IDW-1:0]   RR_RESET  = IDW'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] syncMeta_q, syncOut_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [CNTW-1:0]    debCnt_q [NUM_BTN];
  logic [CNTW-1:0]    debCnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] overflow_q, overflow_d;
  logic [IDW-1:0]     rrPtr_q, rrPtr_d;
  logic [IDW-1:0]     fifoMem_q [FIFO_DEPTH];
  logic [PTRW-1:0]    wrPtr_q, rdPtr_q;
  logic [CNTFW-1:0]   fifoCount_q, fifoCount_d;
  logic               irqEn_q, irqEn_d;
  logic [31:0]        readdata_q, readdata_d;

  logic [NUM_BTN-1:0] pressEvent;
  logic [NUM_BTN-1:0] grantMask;
  logic [IDW-1:0]     grantIdx;
  logic [IDW-1:0]     candIdx;
  logic               grantValid;
  logic               fifoFull, fifoEmpty;
  logic               rdEn, wrEn, readPop;
  logic [31:0]        statusWord;
  logic [7:0]         headCount8, headId8;
  int                 idx;
  logic               unusedWriteBits;

  assign rdEn      = chipselect & ~read_n;
  assign wrEn      = chipselect & ~write_n;
  assign fifoFull  = (fifoCount_q == FIFO_FULL);
  assign fifoEmpty = (fifoCount_q == '0);
  assign readPop   = rdEn && (address == 2'd0) && !fifoEmpty;
  assign unusedWriteBits = ^writedata;

  // Only a stable 1->0 transition counts as a press; releases just update the level.
  always_comb begin
    debCnt_d   = debCnt_q;
    stable_d   = stable_q;
    pressEvent = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (syncOut_q[i] == stable_q[i]) begin
        debCnt_d[i] = '0;
      end else if (debCnt_q[i] == DEB_LAST) begin
        debCnt_d[i]   = '0;
        stable_d[i]   = syncOut_q[i];
        pressEvent[i] = stable_q[i];
      end else begin
        debCnt_d[i] = debCnt_q[i] + 1'b1;
      end
    end
  end

  // Scan downward so the nearest pending index after the pointer is the last one written.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    idx        = 0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      candIdx = IDW'(idx);
      if (!fifoFull && pending_q[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
    grantMask = grantValid ? (NUM_BTN'(1) << grantIdx) : '0;
  end

  always_comb begin
    pending_d  = (pending_q & ~grantMask) | pressEvent;
    overflow_d = overflow_q;
    if (wrEn && address == 2'd2) overflow_d = overflow_q & ~writedata[16 +: NUM_BTN];
    overflow_d = overflow_d | (pressEvent & pending_q & ~grantMask);
    rrPtr_d    = grantValid ? grantIdx : rrPtr_q;
    irqEn_d    = (wrEn && address == 2'd1) ? writedata[0] : irqEn_q;
    unique case ({grantValid, readPop})
      2'b10:   fifoCount_d = fifoCount_q + 1'b1;
      2'b01:   fifoCount_d = fifoCount_q - 1'b1;
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  always_comb begin
    statusWord               = '0;
    statusWord[NUM_BTN-1:0]  = pending_q;
    statusWord[16 +: NUM_BTN] = overflow_q;
    headCount8               = 8'(fifoCount_q);
    headId8                  = 8'(fifoMem_q[rdPtr_q]);
    readdata_d               = readdata_q;
    if (rdEn) begin
      unique case (address)
        2'd0:    readdata_d = fifoEmpty ? 32'd0 : {1'b1, 7'd0, headCount8, 8'd0, headId8};
        2'd1:    readdata_d = {31'd0, irqEn_q};
        2'd2:    readdata_d = statusWord;
        default: readdata_d = 32'(stable_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta_q  <= '1;
      syncOut_q   <= '1;
      stable_q    <= '1;
      for (int i = 0; i < NUM_BTN; i++) debCnt_q[i] <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      rrPtr_q     <= RR_RESET;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
      irqEn_q     <= 1'b0;
      readdata_q  <= '0;
    end else begin
      syncMeta_q  <= in_port;
      syncOut_q   <= syncMeta_q;
      stable_q    <= stable_d;
      for (int i = 0; i < NUM_BTN; i++) debCnt_q[i] <= debCnt_d[i];
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      rrPtr_q     <= rrPtr_d;
      fifoCount_q <= fifoCount_d;
      irqEn_q     <= irqEn_d;
      readdata_q  <= readdata_d;
      if (grantValid) wrPtr_q <= wrPtr_q + 1'b1;
      if (readPop)    rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grantValid) fifoMem_q[wrPtr_q] <= grantIdx;
  end

  assign readdata = readdata_q;
  assign irq      = irqEn_q & ~fifoEmpty;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with a short debounce window and a 4-deep FIFO.
module tb_button_event_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int          vectorCount = 0;
  int          missCount   = 0;
  logic [31:0] rd;

  button_event_scheduler #(
    .NUM_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_port(in_port),
    .address(address),
    .chipselect(chipselect),
    .read_n(read_n),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Pins are held for the given number of rising edges; returns just after the last one.
  task automatic applyStimulus(input logic [3:0] pins, input int cycles);
    @(negedge clk);
    in_port = pins;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address    = addr;
    chipselect = 1'b1;
    read_n     = 1'b0;
    @(posedge clk);
    #1;
    data       = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_port = 4'hF; address = 2'd0; chipselect = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_readdata", readdata, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    busRead(2'd3, rd); checkOutput("rst_level", rd, 32'h0000_000F);
    busRead(2'd1, rd); checkOutput("rst_ctrl", rd, 32'd0);
    busRead(2'd2, rd); checkOutput("rst_status", rd, 32'd0);
    busRead(2'd0, rd); checkOutput("rst_event", rd, 32'd0);

    // Mid-run reset with two queued events and the interrupt live.
    busWrite(2'd1, 32'd1);
    applyStimulus(4'b1100, 10);
    applyStimulus(4'hF, 10);
    checkOutput("pre_rst_irq", {31'd0, irq}, 32'd1);
    busRead(2'd1, rd); checkOutput("pre_rst_ctrl", rd, 32'd1);
    pulseReset();
    checkOutput("mid_rst_readdata", readdata, 32'd0);
    checkOutput("mid_rst_irq", {31'd0, irq}, 32'd0);
    busRead(2'd0, rd); checkOutput("mid_rst_event", rd, 32'd0);
    busRead(2'd1, rd); checkOutput("mid_rst_ctrl", rd, 32'd0);
    busRead(2'd3, rd); checkOutput("mid_rst_level", rd, 32'h0000_000F);

    // Round-robin from the reset pointer (3): 0,2,3 then 0,3.
    applyStimulus(4'b0010, 10);
    applyStimulus(4'hF, 10);
    checkOutput("rr_irq_masked", {31'd0, irq}, 32'd0);
    busRead(2'd0, rd); checkOutput("rr_a0", rd, 32'h8003_0000);
    busRead(2'd0, rd); checkOutput("rr_a1", rd, 32'h8002_0002);
    busRead(2'd0, rd); checkOutput("rr_a2", rd, 32'h8001_0003);
    applyStimulus(4'b0110, 10);
    applyStimulus(4'hF, 10);
    busRead(2'd0, rd); checkOutput("rr_b0", rd, 32'h8002_0000);
    busRead(2'd0, rd); checkOutput("rr_b1", rd, 32'h8001_0003);

    // A 3-cycle glitch is rejected; a long press yields one event.
    applyStimulus(4'b1101, 3);
    applyStimulus(4'hF, 10);
    busRead(2'd0, rd); checkOutput("glitch_event", rd, 32'd0);
    busRead(2'd2, rd); checkOutput("glitch_status", rd, 32'd0);
    applyStimulus(4'b1101, 10);
    busRead(2'd3, rd); checkOutput("held_level", rd, 32'h0000_000D);
    applyStimulus(4'hF, 10);
    busRead(2'd0, rd); checkOutput("press_event", rd, 32'h8001_0001);
    busRead(2'd0, rd); checkOutput("press_empty", rd, 32'd0);

    // Pointer is now 1, so a full press queues 2,3,0,1 and fills the FIFO.
    busWrite(2'd1, 32'd1);
    applyStimulus(4'b0000, 10);
    applyStimulus(4'hF, 10);
    applyStimulus(4'b1011, 10);
    applyStimulus(4'hF, 10);
    checkOutput("full_irq", {31'd0, irq}, 32'd1);
    busRead(2'd2, rd); checkOutput("full_pending", rd, 32'h0000_0004);
    applyStimulus(4'b1011, 10);
    applyStimulus(4'hF, 10);
    busRead(2'd2, rd); checkOutput("ovf_status", rd, 32'h0004_0004);
    busRead(2'd0, rd); checkOutput("full_pop", rd, 32'h8004_0002);
    busRead(2'd2, rd); checkOutput("push_next_pre", rd, 32'h0004_0004);
    busRead(2'd2, rd); checkOutput("push_next_post", rd, 32'h0004_0000);
    busRead(2'd0, rd); checkOutput("refill_pop", rd, 32'h8004_0003);

    busWrite(2'd2, 32'h0004_0000);
    busRead(2'd2, rd); checkOutput("w1c_status", rd, 32'd0);
    busWrite(2'd3, 32'd0);
    busRead(2'd3, rd); checkOutput("level_ro", rd, 32'h0000_000F);
    busRead(2'd0, rd); checkOutput("drain_0", rd, 32'h8003_0000);
    busRead(2'd0, rd); checkOutput("drain_1", rd, 32'h8002_0001);
    checkOutput("drain_irq_on", {31'd0, irq}, 32'd1);
    busRead(2'd0, rd); checkOutput("drain_2", rd, 32'h8001_0002);
    checkOutput("drain_irq_off", {31'd0, irq}, 32'd0);
    busRead(2'd0, rd); checkOutput("drain_empty", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
